// File: rtl/ddr4_v2_2_20_axi_w_channel_if.sv
// Signal bundle for the AXI W-channel to MC write-data bridge: AXI W beats,
// AW-side command pushes and the MC write-data port.
interface ddr4_v2_2_20_axi_w_channel_if #(
    parameter int C_DATA_WIDTH = 32
);
    logic [C_DATA_WIDTH-1:0]   wdata;
    logic [C_DATA_WIDTH/8-1:0] wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic                      w_push;
    logic                      w_ignore_begin;
    logic                      w_ignore_end;
    logic                      w_data_rdy;
    logic                      w_done;
    logic [C_DATA_WIDTH-1:0]   mc_app_wdf_data;
    logic [C_DATA_WIDTH/8-1:0] mc_app_wdf_mask;
    logic                      mc_app_wdf_wren;
    logic                      mc_app_wdf_end;
    logic                      mc_app_wdf_rdy;

    modport master (
        output wdata, wstrb, wlast, wvalid, w_push, w_ignore_begin, w_ignore_end, mc_app_wdf_rdy,
        input  wready, w_data_rdy, w_done, mc_app_wdf_data, mc_app_wdf_mask, mc_app_wdf_wren,
               mc_app_wdf_end
    );

    modport slave (
        input  wdata, wstrb, wlast, wvalid, w_push, w_ignore_begin, w_ignore_end, mc_app_wdf_rdy,
        output wready, w_data_rdy, w_done, mc_app_wdf_data, mc_app_wdf_mask, mc_app_wdf_wren,
               mc_app_wdf_end
    );
endinterface

// File: rtl/ddr4_v2_2_20_axi_w_channel.sv
// AXI write-data to MC write-data bridge: queues per-command filler flags from
// the AW side and emits one or two MC beats per command, inserting filler beats.
module ddr4_v2_2_20_axi_w_channel #(
    parameter int C_DATA_WIDTH   = 32,
    parameter int C_MC_BURST_LEN = 1,
    parameter int C_TRANS_DEPTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    ddr4_v2_2_20_axi_w_channel_if.slave   bus
);
    localparam int STRB_W = C_DATA_WIDTH / 8;
    localparam int PTR_W  = $clog2(C_TRANS_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(C_TRANS_DEPTH);
    localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(C_TRANS_DEPTH - 2);
    localparam logic IS_BL2 = (C_MC_BURST_LEN == 2);

    typedef enum logic [1:0] {ST_IDLE, ST_BEAT0, ST_BEAT1} state_t;

    state_t             state_r, state_nxt_s;
    logic [1:0]         fifo_mem_r [C_TRANS_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r, rd_ptr_r;
    logic [CNT_W-1:0]   count_r, count_nxt_s;
    logic               data_rdy_r;
    logic               ign_begin_r, ign_end_r;
    logic [C_DATA_WIDTH-1:0] data_r, ld_data_s;
    logic [STRB_W-1:0]  mask_r, ld_mask_s;
    logic               wren_r, end_r, done_r;
    logic               fifo_empty_s, push_s, pop_s, out_accept_s;
    logic               wready_s, load_s, ld_end_s, filler_s, final_s;

    assign fifo_empty_s = (count_r == {CNT_W{1'b0}});
    assign push_s       = bus.w_push & (count_r != DEPTH_CNT);
    assign out_accept_s = ~wren_r | bus.mc_app_wdf_rdy;
    assign count_nxt_s  = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

    // Transaction FIFO storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {bus.w_ignore_begin, bus.w_ignore_end};
        end
    end

    // Transaction FIFO pointers, occupancy and the early-backpressure flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            data_rdy_r <= 1'b1;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r    <= count_nxt_s;
            data_rdy_r <= (count_nxt_s < RDY_LIMIT);
        end
    end

    // State register and flags of the command currently being emitted
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            ign_begin_r <= 1'b0;
            ign_end_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (pop_s) begin
                {ign_begin_r, ign_end_r} <= fifo_mem_r[rd_ptr_r];
            end
        end
    end

    // Next state, FIFO pop, AXI ready and the beat to load into the output register
    always_comb begin
        state_nxt_s = state_r;
        pop_s       = 1'b0;
        wready_s    = 1'b0;
        load_s      = 1'b0;
        ld_data_s   = {C_DATA_WIDTH{1'b0}};
        ld_mask_s   = {STRB_W{1'b0}};
        ld_end_s    = 1'b0;
        filler_s    = 1'b0;
        final_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_BEAT0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BEAT0: begin
                filler_s = IS_BL2 & ign_begin_r;
                final_s  = ~IS_BL2;
            end
            ST_BEAT1: begin
                filler_s = ign_end_r;
                final_s  = 1'b1;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if ((state_r == ST_BEAT0) || (state_r == ST_BEAT1)) begin
            if (filler_s) begin
                load_s    = out_accept_s;
                ld_mask_s = {STRB_W{1'b1}};
            end else begin
                wready_s  = out_accept_s;
                load_s    = out_accept_s & bus.wvalid;
                ld_data_s = bus.wdata;
                ld_mask_s = ~bus.wstrb;
            end
            if (load_s) begin
                ld_end_s = final_s;
                // Chain straight into the next command so back-to-back traffic has no bubble
                if (!final_s) begin
                    state_nxt_s = ST_BEAT1;
                end else if (!fifo_empty_s) begin
                    pop_s       = 1'b1;
                    state_nxt_s = ST_BEAT0;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end else begin
                state_nxt_s = state_r;
            end
        end else begin
            ld_end_s = 1'b0;
        end
    end

    // MC output register: loads a new beat, retires an accepted one, or holds under backpressure
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_r <= {C_DATA_WIDTH{1'b0}};
            mask_r <= {STRB_W{1'b0}};
            wren_r <= 1'b0;
            end_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (load_s) begin
                data_r <= ld_data_s;
                mask_r <= ld_mask_s;
                wren_r <= 1'b1;
                end_r  <= ld_end_s;
            end else if (out_accept_s) begin
                wren_r <= 1'b0;
                end_r  <= 1'b0;
            end else begin
                wren_r <= wren_r;
                end_r  <= end_r;
            end
            done_r <= load_s & final_s;
        end
    end

    assign bus.wready          = wready_s;
    assign bus.w_data_rdy      = data_rdy_r;
    assign bus.w_done          = done_r;
    assign bus.mc_app_wdf_data = data_r;
    assign bus.mc_app_wdf_mask = mask_r;
    assign bus.mc_app_wdf_wren = wren_r;
    assign bus.mc_app_wdf_end  = end_r;
endmodule

// File: tb/tb_ddr4_v2_2_20_axi_w_channel.sv
// Bench for the W-channel bridge: a BL4 and a BL8 instance share one stimulus
// set (sel picks the active one) and are checked against a command/beat queue model.
module tb_ddr4_v2_2_20_axi_w_channel;
    localparam int DW = 32;
    localparam int SW = 4;

    typedef struct packed { logic ib; logic ie; } ent_t;

    logic clk, reset_n, sel, push, ib, ie, wvalid, wlast, rdy;
    logic [DW-1:0] wdata;
    logic [SW-1:0] wstrb;
    logic s_wready, s_w_data_rdy, s_w_done, s_wren, s_end;
    logic [DW-1:0] s_data;
    logic [SW-1:0] s_mask;

    int n_tests = 0;
    int n_fail  = 0;
    ent_t ent_q[$];
    logic [DW+SW-1:0] axi_q[$];
    logic [DW+SW:0] log_q[$];
    int beat_idx = 0;
    int hs_cnt = 0, done_cnt = 0, ends_cnt = 0;
    int wait_n, base_done, base_hs;
    ent_t cur_e;
    logic [DW+SW-1:0] cur_ab;
    logic exp_filler, exp_last;
    logic [DW-1:0] exp_data;
    logic [SW-1:0] exp_mask;
    logic prev_ok, prev_wren, prev_rdy, prev_end;
    logic [DW-1:0] prev_data;
    logic [SW-1:0] prev_mask;

    ddr4_v2_2_20_axi_w_channel_if #(.C_DATA_WIDTH(DW)) bus1 ();
    ddr4_v2_2_20_axi_w_channel_if #(.C_DATA_WIDTH(DW)) bus2 ();

    ddr4_v2_2_20_axi_w_channel #(.C_DATA_WIDTH(DW), .C_MC_BURST_LEN(1), .C_TRANS_DEPTH(16))
        dut_bl1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    ddr4_v2_2_20_axi_w_channel #(.C_DATA_WIDTH(DW), .C_MC_BURST_LEN(2), .C_TRANS_DEPTH(16))
        dut_bl2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    assign bus1.w_push = push & ~sel;
    assign bus2.w_push = push & sel;
    assign bus1.wvalid = wvalid & ~sel;
    assign bus2.wvalid = wvalid & sel;
    assign bus1.w_ignore_begin = ib;
    assign bus2.w_ignore_begin = ib;
    assign bus1.w_ignore_end = ie;
    assign bus2.w_ignore_end = ie;
    assign bus1.wdata = wdata;
    assign bus2.wdata = wdata;
    assign bus1.wstrb = wstrb;
    assign bus2.wstrb = wstrb;
    assign bus1.wlast = wlast;
    assign bus2.wlast = wlast;
    assign bus1.mc_app_wdf_rdy = rdy;
    assign bus2.mc_app_wdf_rdy = rdy;

    assign s_wready     = sel ? bus2.wready          : bus1.wready;
    assign s_w_data_rdy = sel ? bus2.w_data_rdy      : bus1.w_data_rdy;
    assign s_w_done     = sel ? bus2.w_done          : bus1.w_done;
    assign s_wren       = sel ? bus2.mc_app_wdf_wren : bus1.mc_app_wdf_wren;
    assign s_end        = sel ? bus2.mc_app_wdf_end  : bus1.mc_app_wdf_end;
    assign s_data       = sel ? bus2.mc_app_wdf_data : bus1.mc_app_wdf_data;
    assign s_mask       = sel ? bus2.mc_app_wdf_mask : bus1.mc_app_wdf_mask;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: scoreboard of AXI beats and commands against the MC beat stream
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_ok = 1'b0;
        end else begin
            if (wvalid && s_wready) begin
                axi_q.push_back({wdata, wstrb});
                hs_cnt++;
            end
            if (s_w_done) begin
                done_cnt++;
                check("done_with_end", {62'd0, s_wren, s_end}, 64'd3);
            end
            if (prev_ok && prev_wren && !prev_rdy) begin
                check("stall_hold", {s_wren, s_end, s_mask, s_data},
                      {prev_wren, prev_end, prev_mask, prev_data});
            end
            if (ent_q.size() == 0) begin
                check("idle_wready", {63'd0, s_wready}, 64'd0);
            end
            if (s_wren && rdy) begin
                if (ent_q.size() == 0) begin
                    check("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    cur_e = ent_q[0];
                    exp_last = !sel || (beat_idx == 1);
                    exp_filler = sel && ((beat_idx == 0) ? cur_e.ib : cur_e.ie);
                    exp_data = '0;
                    exp_mask = '1;
                    if (!exp_filler) begin
                        if (axi_q.size() == 0) begin
                            check("beat_without_axi", 64'd1, 64'd0);
                        end else begin
                            cur_ab = axi_q.pop_front();
                            exp_data = cur_ab[DW+SW-1:SW];
                            exp_mask = ~cur_ab[SW-1:0];
                        end
                    end
                    check("beat_data", {32'd0, s_data}, {32'd0, exp_data});
                    check("beat_mask", {60'd0, s_mask}, {60'd0, exp_mask});
                    check("beat_end", {63'd0, s_end}, {63'd0, exp_last});
                    log_q.push_back({s_end, s_mask, s_data});
                    if (exp_last) begin
                        void'(ent_q.pop_front());
                        beat_idx = 0;
                        ends_cnt++;
                    end else begin
                        beat_idx = 1;
                    end
                end
            end
            prev_ok = 1'b1;
            prev_wren = s_wren;
            prev_rdy = rdy;
            prev_end = s_end;
            prev_data = s_data;
            prev_mask = s_mask;
        end
    end

    // All directed tasks start and end 1 time unit after a rising edge
    task automatic push_cmd(input logic b, input logic e);
        push = 1'b1; ib = b; ie = e;
        ent_q.push_back('{ib: b, ie: e});
        @(posedge clk); #1;
        push = 1'b0;
    endtask

    task automatic push_check_latency(input logic b, input logic e);
        push = 1'b1; ib = b; ie = e;
        ent_q.push_back('{ib: b, ie: e});
        @(negedge clk);
        check("lat_k0_wready", {63'd0, s_wready}, 64'd0);
        @(posedge clk); #1;
        push = 1'b0;
        @(negedge clk);
        check("lat_k1_wready", {63'd0, s_wready}, 64'd0);
        @(negedge clk);
        check("lat_k2_wready", {63'd0, s_wready}, 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic axi_beat(input logic [DW-1:0] d, input logic [SW-1:0] s);
        wdata = d; wstrb = s; wvalid = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (s_wready) begin
                @(posedge clk); #1;
                return;
            end
        end
        check("axi_timeout", 64'd1, 64'd0);
    endtask

    task automatic wait_quiet();
        for (int n = 0; n < 500 && ent_q.size() != 0; n++) begin
            @(posedge clk);
        end
        #1;
        check("drain_timeout", {63'd0, ent_q.size() == 0}, 64'd1);
        @(posedge clk); #1;
    endtask

    initial begin
        sel = 1'b0; push = 1'b0; ib = 1'b0; ie = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        rdy = 1'b1; wdata = '0; wstrb = '0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        check("rst_w_data_rdy", {63'd0, s_w_data_rdy}, 64'd1);
        check("rst_wready", {63'd0, s_wready}, 64'd0);
        check("rst_outputs", {s_wren, s_end, s_w_done, s_mask, s_data}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;

        // BL4: single command, two-cycle wready latency, wren one cycle after handshake
        log_q.delete(); base_done = done_cnt;
        push_check_latency(1'b0, 1'b0);
        axi_beat(32'hA5A5A5A5, 4'hF);
        wvalid = 1'b0;
        @(negedge clk);
        check("wren_latency", {63'd0, s_wren}, 64'd1);
        @(posedge clk); #1;
        wait_quiet();
        check("bl1_beats", log_q.size(), 64'd1);
        check("bl1_beat0", log_q[0], {1'b1, 4'h0, 32'hA5A5A5A5});
        check("bl1_done", done_cnt - base_done, 64'd1);

        // BL4 ignores the filler flags
        log_q.delete();
        push_cmd(1'b1, 1'b1);
        axi_beat(32'hDEADBEEF, 4'h5);
        wvalid = 1'b0;
        wait_quiet();
        check("bl1_ignflags", log_q.size() == 1 ? log_q[0] : 37'd0, {1'b1, 4'hA, 32'hDEADBEEF});

        // BL8 with a leading filler beat
        sel = 1'b1; log_q.delete(); base_hs = hs_cnt;
        push_cmd(1'b1, 1'b0);
        axi_beat(32'h12345678, 4'h3);
        wvalid = 1'b0;
        wait_quiet();
        check("bl2_ib_beats", log_q.size(), 64'd2);
        check("bl2_ib_beat0", log_q[0], {1'b0, 4'hF, 32'h0});
        check("bl2_ib_beat1", log_q[1], {1'b1, 4'hC, 32'h12345678});
        check("bl2_ib_hs", hs_cnt - base_hs, 64'd1);

        // BL8 with both beats filler: no AXI beat consumed
        log_q.delete(); base_hs = hs_cnt;
        push_cmd(1'b1, 1'b1);
        wait_quiet();
        check("bl2_both_beats", log_q.size(), 64'd2);
        check("bl2_both_beat1", log_q[1], {1'b1, 4'hF, 32'h0});
        check("bl2_both_hs", hs_cnt - base_hs, 64'd0);

        // BL8 back-to-back: six consecutive beats, end on every second one
        log_q.delete();
        fork
            begin
                push_cmd(1'b0, 1'b0); push_cmd(1'b0, 1'b0); push_cmd(1'b0, 1'b0);
            end
            begin
                for (int i = 0; i < 6; i++) axi_beat(32'hB0000000 + i, 4'hF);
                wvalid = 1'b0;
            end
            begin
                wait_n = 0;
                @(negedge clk);
                while (!s_wren && wait_n < 50) begin @(negedge clk); wait_n++; end
                for (int k = 1; k <= 6; k++) begin
                    check("b2b_wren", {63'd0, s_wren}, 64'd1);
                    check("b2b_end", {63'd0, s_end}, {63'd0, (k % 2) == 0});
                    if (k < 6) @(negedge clk);
                end
            end
        join
        @(posedge clk); #1;
        wait_quiet();
        check("b2b_beats", log_q.size(), 64'd6);

        // MC backpressure for five cycles in the middle of a burst
        log_q.delete();
        fork
            begin push_cmd(1'b0, 1'b0); push_cmd(1'b0, 1'b0); end
            begin
                for (int i = 0; i < 4; i++) axi_beat(32'hC0000000 + i, 4'hF);
                wvalid = 1'b0;
            end
            begin
                wait_n = 0;
                @(negedge clk);
                while (!s_wren && wait_n < 50) begin @(negedge clk); wait_n++; end
                @(posedge clk); #1;
                rdy = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_wready", {63'd0, s_wready}, 64'd0);
                    check("stall_wren", {63'd0, s_wren}, 64'd1);
                end
                @(posedge clk); #1;
                rdy = 1'b1;
            end
        join
        wait_quiet();
        check("stall_beats", log_q.size(), 64'd4);
        check("stall_last", log_q[3], {1'b1, 4'h0, 32'hC0000003});

        // Fill the BL4 FIFO with no AXI data; the first entry sits in the flag register,
        // so pushes 1..17 are accepted and the 18th is dropped
        sel = 1'b0; log_q.delete(); base_done = done_cnt;
        push = 1'b1; ib = 1'b0; ie = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            if (i <= 17) ent_q.push_back('{ib: 1'b0, ie: 1'b0});
            @(posedge clk); #1;
            if (i == 18) push = 1'b0;
            @(negedge clk);
            check("fill_w_data_rdy", {63'd0, s_w_data_rdy}, {63'd0, i < 15});
        end
        @(posedge clk); #1;
        for (int i = 0; i < 17; i++) axi_beat(32'h00001000 + i, 4'hF);
        wvalid = 1'b0;
        wait_quiet();
        check("fill_done", done_cnt - base_done, 64'd17);
        check("fill_last", log_q[16], {1'b1, 4'h0, 32'h00001010});
        check("fill_rdy_after", {63'd0, s_w_data_rdy}, 64'd1);

        // Reset while a BL8 command waits in its second beat
        sel = 1'b1;
        push_cmd(1'b0, 1'b0);
        push_cmd(1'b0, 1'b0);
        axi_beat(32'hCAFE0001, 4'hF);
        wvalid = 1'b0;
        check("pre_reset_wren", {63'd0, s_wren}, 64'd1);
        @(negedge clk); #1;
        reset_n = 1'b0;
        ent_q.delete(); axi_q.delete(); beat_idx = 0;
        #1;
        check("mid_rst_outputs", {s_wren, s_end, s_w_done, s_mask, s_data}, 64'd0);
        check("mid_rst_wready", {63'd0, s_wready}, 64'd0);
        check("mid_rst_w_data_rdy", {63'd0, s_w_data_rdy}, 64'd1);
        repeat (3) @(posedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_w_data_rdy", {63'd0, s_w_data_rdy}, 64'd1);
        check("post_rst_wready", {63'd0, s_wready}, 64'd0);
        log_q.delete();
        push_check_latency(1'b0, 1'b0);
        axi_beat(32'hD0000001, 4'hF);
        axi_beat(32'hD0000002, 4'h1);
        wvalid = 1'b0;
        wait_quiet();
        check("post_rst_beats", log_q.size(), 64'd2);
        check("post_rst_beat1", log_q[1], {1'b1, 4'hE, 32'hD0000002});

        repeat (4) @(posedge clk);
        #1;
        check("done_vs_ends", done_cnt, ends_cnt);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_tests);
        $fatal(1);
    end
endmodule
